// File: rtl/div_sched_if.sv
// Request/response bundle for the time-shared divider: per-requester
// num/dem lanes in, one tagged 9-bit ratio out.
interface div_sched_if #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_num;
  logic [N_REQ-1:0][7:0] req_dem;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [8:0]            rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_sat;

  modport master (
    output req_valid, req_num, req_dem,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
  );
  modport slave (
    input  req_valid, req_num, req_dem,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
  );
endinterface

// File: rtl/div_sched.sv
// Arbitrated restoring divider: Q = floor(256*num/dem), saturated to 0x1FF.
// DIV_SCHED_RR_EN selects round-robin grant; otherwise lowest index wins.
module div_sched #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic      clk,
  input  logic      rst,
  div_sched_if.slave bus,
  output logic      busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [8:0]     rem_q, rem_d;
  logic [7:0]     quo_q, quo_d;
  logic [7:0]     dem_q, dem_d;
  logic [3:0]     k_q, k_d;
  logic [IDW-1:0] id_q, id_d;
  logic [8:0]     data_q, data_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic           sat_q, sat_d;

  logic [IDW-1:0] win;
  logic           win_vld;
  logic [7:0]     win_num, win_dem;
  logic           grant_en, acc, sat_chk, ge;
  logic [7:0]     diff;

`ifdef DIV_SCHED_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!win_vld && bus.req_valid[(int'(ptr_q) + off) % N_REQ]) begin
        win     = IDW'((int'(ptr_q) + off) % N_REQ);
        win_vld = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (acc) ptr_d = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win     = IDW'(i);
        win_vld = 1'b1;
      end
    end
  end
`endif

  assign grant_en = !rst && (state_q == IDLE || state_q == DONE);
  assign acc      = grant_en && win_vld;

  always_comb begin
    bus.req_ready = '0;
    win_num       = '0;
    win_dem       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        bus.req_ready[i] = acc;
        win_num          = bus.req_num[i];
        win_dem          = bus.req_dem[i];
      end
    end
  end

  // num >= 2*dem would need a 10th quotient bit; it is folded into saturation
  assign sat_chk = (win_dem == 8'd0) || ({1'b0, win_num} >= {win_dem, 1'b0});
  assign ge      = rem_q >= {1'b0, dem_q};
  // when ge holds, r - dem < dem <= 255, so the low byte is exact
  assign diff    = rem_q[7:0] - dem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dem_d   = dem_q;
    k_d     = k_q;
    id_d    = id_q;
    data_d  = data_q;
    rid_d   = rid_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (acc) begin
          id_d  = win;
          dem_d = win_dem;
          rem_d = {1'b0, win_num};
          quo_d = '0;
          k_d   = 4'd8;
          if (sat_chk) begin
            state_d = DONE;
            data_d  = 9'h1FF;
            rid_d   = win;
            sat_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        quo_d = {quo_q[6:0], ge};
        rem_d = ge ? {diff, 1'b0} : {rem_q[7:0], 1'b0};
        if (k_q == 4'd0) begin
          state_d = DONE;
          data_d  = {quo_q, ge};
          rid_d   = id_q;
          sat_d   = 1'b0;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dem_q   <= '0;
      k_q     <= 4'd8;
      id_q    <= '0;
      data_q  <= '0;
      rid_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dem_q   <= dem_d;
      k_q     <= k_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_sat   = sat_q;
  assign busy          = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed and random ratios against an
// arithmetic model, arbitration order, mid-run reset and back-to-back grant.
module tb_div_sched;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_sched_if #(.N_REQ(N), .IDW(IDW)) bus();
  div_sched #(.N_REQ(N), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  function automatic int ref_q(input int num, input int dem);
    if (dem == 0 || num >= 2 * dem) return 511;
    return (num * 256) / dem;
  endfunction

  function automatic bit ref_sat(input int num, input int dem);
    return (dem == 0 || num >= 2 * dem);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_num   = '0;
    bus.req_dem   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request and waits for its response; returns what was observed.
  task automatic issue(input int id, input int num, input int dem,
                       output int lat, output logic [8:0] d, output logic [IDW-1:0] rid,
                       output logic s, output logic b1, output bit ok);
    int w;
    ok = 1'b0; lat = -1; d = '0; rid = '0; s = 1'b0; b1 = 1'b0;
    @(negedge clk);
    bus.req_valid[id] = 1'b1;
    bus.req_num[id]   = 8'(num);
    bus.req_dem[id]   = 8'(dem);
    #1;
    w = 0;
    while (!bus.req_ready[id] && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!bus.req_ready[id]) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    #1;
    b1 = busy;
    for (int c = 1; c <= 20; c++) begin
      if (bus.rsp_valid) begin
        lat = c; d = bus.rsp_data; rid = bus.rsp_id; s = bus.rsp_sat; ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 9'd0 || bus.rsp_id !== '0 ||
        bus.rsp_sat !== 1'b0 || busy !== 1'b0 || bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: actual v=%b d=%0d id=%0d sat=%b busy=%b rdy=%b required all zero",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_sat, busy, bus.req_ready);
    end
  endtask

  task automatic check_one(input string nm, input int id, input int num, input int dem);
    int lat, exp_lat;
    logic [8:0] d;
    logic [IDW-1:0] rid;
    logic s, b1;
    bit ok;
    issue(id, num, dem, lat, d, rid, s, b1, ok);
    exp_lat = ref_sat(num, dem) ? 1 : 10;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: num=%0d dem=%0d actual=no response required=response", nm, num, dem);
      return;
    end
    n_tests++;
    if (d !== 9'(ref_q(num, dem))) begin
      n_fail++;
      $display("FAIL %s_data: num=%0d dem=%0d actual=%0d required=%0d", nm, num, dem, d, ref_q(num, dem));
    end
    n_tests++;
    if (s !== ref_sat(num, dem)) begin
      n_fail++;
      $display("FAIL %s_sat: num=%0d dem=%0d actual=%b required=%b", nm, num, dem, s, ref_sat(num, dem));
    end
    n_tests++;
    if (rid !== IDW'(id)) begin
      n_fail++;
      $display("FAIL %s_id: actual=%0d required=%0d", nm, rid, id);
    end
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: num=%0d dem=%0d actual=%0d required=%0d", nm, num, dem, lat, exp_lat);
    end
    n_tests++;
    if (b1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: actual=%b required=1", nm, b1);
    end
  endtask

  task automatic test_directed();
    int tn[6] = '{100, 255, 1, 0, 3, 5};
    int td[6] = '{200, 255, 3, 7, 1, 0};
    for (int i = 0; i < 6; i++) check_one("directed", i % N, tn[i], td[i]);
  endtask

  task automatic test_random();
    int num, dem;
    for (int i = 0; i < 24; i++) begin
      num = $urandom_range(0, 255);
      dem = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      check_one("random", $urandom_range(0, N - 1), num, dem);
    end
  endtask

  task automatic test_arbitration();
    int gid[$];
    int gcyc[$];
    int exp_id;
    do_reset();
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_num[i] = 8'd10;
      bus.req_dem[i] = 8'd20;
    end
    for (int cyc = 0; cyc < 100 && gid.size() < 6; cyc++) begin
      #1;
      if (bus.req_ready != '0) begin
        n_tests++;
        if (!$onehot(bus.req_ready)) begin
          n_fail++;
          $display("FAIL arb_onehot: actual=%b required=one-hot", bus.req_ready);
        end
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid.push_back(i);
        gcyc.push_back(cyc);
        n_tests++;
        if (bus.rsp_valid !== (gid.size() > 1)) begin
          n_fail++;
          $display("FAIL arb_grant_in_done: grant=%0d actual rsp_valid=%b required=%b",
                   gid.size(), bus.rsp_valid, gid.size() > 1);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    n_tests++;
    if (gid.size() != 6) begin
      n_fail++;
      $display("FAIL arb_grant_count: actual=%0d required=6", gid.size());
    end
    for (int k = 0; k < gid.size(); k++) begin
`ifdef DIV_SCHED_RR_EN
      exp_id = k % N;
`else
      exp_id = 0;
`endif
      n_tests++;
      if (gid[k] != exp_id) begin
        n_fail++;
        $display("FAIL arb_order: grant=%0d actual=%0d required=%0d", k, gid[k], exp_id);
      end
      if (k > 0) begin
        n_tests++;
        if (gcyc[k] - gcyc[k-1] != 10) begin
          n_fail++;
          $display("FAIL arb_interval: grant=%0d actual=%0d required=10", k, gcyc[k] - gcyc[k-1]);
        end
      end
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_num[0] = 8'd50; bus.req_dem[0] = 8'd100;
    #1;
    c = 0;
    while (!bus.req_ready[0] && c < 50) begin @(negedge clk); #1; c++; end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.req_valid[1] = 1'b1; bus.req_num[1] = 8'd77; bus.req_dem[1] = 8'd200;
    @(negedge clk); #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 9'd0 || bus.rsp_id !== '0 ||
        bus.rsp_sat !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: actual v=%b d=%0d id=%0d sat=%b busy=%b required all zero",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_sat, busy);
    end
    n_tests++;
    if (bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL ready_in_reset: actual=%b required=000", bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL post_reset_grant: actual=%b required=010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    c = 1;
    while (!bus.rsp_valid && c <= 20) begin @(negedge clk); #1; c++; end
    n_tests++;
    if (c != 10 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 9'(ref_q(77, 200))) begin
      n_fail++;
      $display("FAIL post_reset_request: actual lat=%0d id=%0d d=%0d required lat=10 id=1 d=%0d",
               c, bus.rsp_id, bus.rsp_data, ref_q(77, 200));
    end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_num[0] = 8'd60; bus.req_dem[0] = 8'd100;
    #1;
    c = 0;
    while (!bus.req_ready[0] && c < 50) begin @(negedge clk); #1; c++; end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_num[1] = 8'd7; bus.req_dem[1] = 8'd9;
    #1;
    c = 1;
    while (!bus.rsp_valid && c <= 20) begin @(negedge clk); #1; c++; end
    n_tests++;
    if (c != 10 || bus.req_ready !== 3'b010 || bus.rsp_id !== 2'd0 ||
        bus.rsp_data !== 9'(ref_q(60, 100))) begin
      n_fail++;
      $display("FAIL b2b_first: actual lat=%0d rdy=%b id=%0d d=%0d required lat=10 rdy=010 id=0 d=%0d",
               c, bus.req_ready, bus.rsp_id, bus.rsp_data, ref_q(60, 100));
    end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    c = 1;
    while (!bus.rsp_valid && c <= 20) begin @(negedge clk); #1; c++; end
    n_tests++;
    if (c != 10 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 9'(ref_q(7, 9)) || bus.rsp_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: actual lat=%0d id=%0d d=%0d sat=%b required lat=10 id=1 d=%0d sat=0",
               c, bus.rsp_id, bus.rsp_data, bus.rsp_sat, ref_q(7, 9));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_num   = '0;
    bus.req_dem   = '0;
    test_reset();
    test_directed();
    test_random();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_sched.md
# div_sched

Time-shared divide engine for the pixel-ratio path. It accepts 8-bit numerator/denominator pairs from N_REQ requesters, such as per-channel gain units. Requesters are arbitrated onto a single iterative restoring divider that resolves one quotient bit per clock. The divider returns a 9-bit fixed-point ratio Q = floor(256·num/dem), saturated to 0x1FF, tagged with the requester index. This replaces one combinational divider per channel with one sequenced divider.

## Interface
- N_REQ, 3: number of requesters (2..8).
- IDW, 2: width of rsp_id, which must satisfy 2^IDW ≥ N_REQ.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request strobe.
- req_num  in  8·N_REQ  numerators; requester i uses bits [8i+7:8i].
- req_dem  in  8·N_REQ  denominators, same packing as req_num.
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_data  out  9  quotient, 1.8 unsigned fixed point.
- rsp_id  out  IDW  index of the requester that owns this result.
- rsp_sat  out  1  high with rsp_valid when the result saturated (num ≥ 2·dem or dem = 0).
- busy  out  1  high in states RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Requester rules: once a requester raises req_valid[i], it holds req_valid[i], its num and its dem stable until it sees req_ready[i]. A requester may not withdraw a request.
- Grant:
  - req_ready is combinational.
  - At most one bit of req_ready is high, and only in IDLE or DONE, and only when rst = 0.
  - The winner is the first valid index at or after the priority pointer, searching upward and wrapping.
- On accept, the engine captures num, dem and the winner's id. The pointer moves to (winner+1) mod N_REQ.
- Saturation check, performed on accept:
  - If dem = 0 or num ≥ 2·dem, the next state is DONE with rsp_data = 0x1FF and rsp_sat = 1.
  - Otherwise the next state is RUN.
- Datapath in RUN:
  - 9-bit remainder r, initialised to num.
  - Bit counter k counts 8 down to 0.
  - Each cycle: if r ≥ dem then q[k] = 1 and r = (r − dem) << 1; otherwise q[k] = 0 and r = r << 1.
  - r never exceeds 2·dem − 2 (at most 508), so 9 bits are sufficient with no overflow.
  - After k = 0 the next state is DONE.
- DONE:
  - rsp_valid = 1 for exactly one cycle. rsp_data, rsp_id and rsp_sat are valid in that same cycle.
  - The arbiter may grant a new request in this same cycle, which gives back-to-back operation. The next state is then RUN (or DONE again if the new request saturates); with no grant it is IDLE.
- Responses have no backpressure. Consumers must take the result in its strobe cycle.

## Timing
- Reset values: every bit of req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_sat = 0, busy = 0, priority pointer = 0, k = 8.
- Latency, with the accept at edge t:
  - Normal request: RUN occupies cycles t+1 through t+9, and rsp_valid is high in cycle t+10.
  - Saturating request: rsp_valid is high in cycle t+1.
- Throughput: one normal result every 10 cycles when requests arrive back-to-back through DONE.
- rsp_data, rsp_id and rsp_sat are registered. They hold their value until the next DONE.
- Reset mid-operation: rst in any state returns the FSM to IDLE on the next edge.
  - The in-flight result is discarded, so no rsp_valid follows.
  - The requester that was being served is not re-granted automatically. Because its request was already accepted, that requester must re-issue it.
- Simultaneous events: a rsp_valid and a req_ready for a different requester (or the same one) in the same DONE cycle is legal and required behaviour.

## Configuration
- DIV_SCHED_RR_EN defined: round-robin arbitration as described above, with the pointer advancing after each grant.
- DIV_SCHED_RR_EN undefined: fixed priority where the lowest valid index always wins. The pointer logic is removed, and starvation of high indices is accepted.

## Test plan
- Single request on requester 0, num = 100, dem = 200: rsp_valid 10 cycles after accept, rsp_data = 128, rsp_id = 0, rsp_sat = 0.
- num = 255, dem = 255 → rsp_data = 256. num = 1, dem = 3 → 85. num = 0, dem = 7 → 0. Each case takes 10 cycles.
- num = 3, dem = 1, and separately num = 5, dem = 0: rsp_valid 1 cycle after accept, rsp_data = 0x1FF, rsp_sat = 1.
- All three requesters valid continuously with DIV_SCHED_RR_EN defined: grant order 0,1,2,0,…, one grant every 10 cycles, each grant in a DONE cycle. With the macro undefined, only requester 0 is ever granted.
- rst asserted at cycle 5 of RUN: no rsp_valid follows, busy drops, and every output reads its reset value after the edge. A new request then completes normally.
- Back-to-back: requester 1 valid when requester 0's DONE arrives: req_ready[1] and rsp_valid (rsp_id = 0) are both high in the same cycle, and requester 1's result arrives 10 cycles later.
